// File: rtl/split_frame_length_if.sv
// AXI4-Stream bundle used on all three ports of split_frame_length.
// tkeep/tlast are carried on every instance so one interface type serves both data and length streams.
interface split_frame_length_if #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = DATA_W / 8
) ();
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/split_frame_length.sv
// Strips the little-endian frame-length header off a combined stream, emits it on its own stream and
// passes payload through combinationally. Define SPLIT_FRAME_LENGTH_CHECK_EN to add the byte-count check.
module split_frame_length #(
    parameter int C_AXIS_TDATA_WIDTH = 8,
    parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
    parameter int FRAME_LENGTH_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    split_frame_length_if.slave  s_axis,
    split_frame_length_if.master m_axis_frame_length,
    split_frame_length_if.master m_axis,
    output logic                 err_truncated,
    output logic                 err_length
);
    localparam int W         = C_AXIS_TDATA_WIDTH;
    localparam int HDR_BEATS = FRAME_LENGTH_WIDTH / W;
    localparam int CNT_W     = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_HDR = CNT_W'(HDR_BEATS - 1);

    typedef enum logic {HEADER, PAYLOAD} state_t;

    state_t                        state, state_nxt;
    logic [CNT_W-1:0]              hdr_cnt, hdr_cnt_nxt;
    logic [FRAME_LENGTH_WIDTH-1:0] len_q;
    logic                          len_vld;
    logic                          hdr_hs, hdr_done, hdr_trunc;

    always_comb begin
        state_nxt     = state;
        hdr_cnt_nxt   = hdr_cnt;
        hdr_hs        = 1'b0;
        hdr_done      = 1'b0;
        hdr_trunc     = 1'b0;
        s_axis.tready = 1'b0;
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = s_axis.tdata;
        m_axis.tkeep  = s_axis.tkeep;
        m_axis.tlast  = s_axis.tlast;
        case (state)
            HEADER: begin
                // a pending length blocks the next header so it cannot be overwritten
                s_axis.tready = !len_vld;
                hdr_hs        = s_axis.tvalid && !len_vld;
                if (hdr_hs) begin
                    if (s_axis.tlast) begin
                        hdr_trunc   = 1'b1;
                        hdr_cnt_nxt = '0;
                    end else if (hdr_cnt == LAST_HDR) begin
                        hdr_done    = 1'b1;
                        hdr_cnt_nxt = '0;
                        state_nxt   = PAYLOAD;
                    end else begin
                        hdr_cnt_nxt = hdr_cnt + 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                s_axis.tready = m_axis.tready;
                m_axis.tvalid = s_axis.tvalid;
                if (s_axis.tvalid && m_axis.tready && s_axis.tlast)
                    state_nxt = HEADER;
            end
            default: state_nxt = HEADER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HEADER;
            hdr_cnt       <= '0;
            len_q         <= '0;
            len_vld       <= 1'b0;
            err_truncated <= 1'b0;
        end else begin
            state         <= state_nxt;
            hdr_cnt       <= hdr_cnt_nxt;
            err_truncated <= hdr_trunc;
            for (int k = 0; k < HDR_BEATS; k++)
                if (hdr_hs && hdr_cnt == CNT_W'(k))
                    len_q[k*W +: W] <= s_axis.tdata;
            if (hdr_done)
                len_vld <= 1'b1;
            else if (len_vld && m_axis_frame_length.tready)
                len_vld <= 1'b0;
        end
    end

    assign m_axis_frame_length.tdata  = len_q;
    assign m_axis_frame_length.tvalid = len_vld;
    assign m_axis_frame_length.tkeep  = '1;
    assign m_axis_frame_length.tlast  = 1'b1;

`ifdef SPLIT_FRAME_LENGTH_CHECK_EN
    localparam int BW = FRAME_LENGTH_WIDTH;

    logic          pay_hs;
    logic [BW-1:0] byte_cnt, beat_bytes, byte_sum;
    logic [BW:0]   sum_wide;

    // len_q cannot change during PAYLOAD, so it is the latched length for the compare
    always_comb begin
        pay_hs     = (state == PAYLOAD) && s_axis.tvalid && m_axis.tready;
        beat_bytes = '0;
        for (int i = 0; i < C_AXIS_TKEEP_WIDTH; i++)
            beat_bytes = beat_bytes + BW'(s_axis.tkeep[i]);
        sum_wide = {1'b0, byte_cnt} + {1'b0, beat_bytes};
        byte_sum = sum_wide[BW] ? '1 : sum_wide[BW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= '0;
            err_length <= 1'b0;
        end else begin
            err_length <= 1'b0;
            if (pay_hs) begin
                if (s_axis.tlast) begin
                    byte_cnt   <= '0;
                    err_length <= (byte_sum != len_q);
                end else begin
                    byte_cnt <= byte_sum;
                end
            end
        end
    end
`else
    assign err_length = 1'b0;
`endif

endmodule

// File: tb/tb_split_frame_length.sv
// Randomized scoreboard bench for split_frame_length; frames are modelled as (length, beat list) tuples.
module tb_split_frame_length;
`ifdef SPLIT_FRAME_LENGTH_CHECK_EN
    localparam int W = 32, FLW = 32;
    localparam bit CHECK_EN = 1'b1;
`else
    localparam int W = 8, FLW = 16;
    localparam bit CHECK_EN = 1'b0;
`endif
    localparam int KW  = W / 8;
    localparam int HB  = FLW / W;
    localparam int TMO = 3000;

    typedef struct packed {
        logic [W-1:0]  d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_trunc, err_len;

    split_frame_length_if #(.DATA_W(W))   s_if ();
    split_frame_length_if #(.DATA_W(W))   m_if ();
    split_frame_length_if #(.DATA_W(FLW)) l_if ();

    split_frame_length #(
        .C_AXIS_TDATA_WIDTH(W),
        .C_AXIS_TKEEP_WIDTH(KW),
        .FRAME_LENGTH_WIDTH(FLW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .s_axis             (s_if),
        .m_axis_frame_length(l_if),
        .m_axis             (m_if),
        .err_truncated      (err_trunc),
        .err_length         (err_len)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    beat_t exp_beats[$];
    logic [FLW-1:0] exp_len[$];
    int exp_trunc = 0, exp_lenerr = 0, obs_trunc = 0, obs_lenerr = 0;
    bit m_rdy_rand = 1'b0, l_hold = 1'b0, gaps = 1'b0, a_done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // sink readiness changes only on the falling edge
    always @(negedge clk) begin
        m_if.tready = m_rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        l_if.tready = !l_hold;
    end

    // monitor: samples one time unit before each rising edge
    always begin
        @(negedge clk);
        #4;
        if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
            if (exp_beats.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL frame_beat: got unexpected beat %0h, none required", m_if.tdata);
            end else begin
                chk("frame_beat", {m_if.tdata, m_if.tkeep, m_if.tlast}, exp_beats.pop_front());
            end
        end
        if (l_if.tvalid === 1'b1 && l_if.tready === 1'b1) begin
            if (exp_len.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL length_beat: got unexpected length %0d, none required", l_if.tdata);
            end else begin
                chk("length_beat", l_if.tdata, exp_len.pop_front());
            end
        end
        if (err_trunc === 1'b1) obs_trunc++;
        if (err_len === 1'b1) obs_lenerr++;
    end

    task automatic send_beat(input logic [W-1:0] d, input logic [KW-1:0] k, input logic l,
                             input bit is_pay);
        int t = 0;
        if (gaps) repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            s_if.tvalid = 1'b0;
        end
        @(negedge clk);
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        forever begin
            #4;
            if (is_pay) chk("ready_mirror", s_if.tready, m_if.tready);
            if (s_if.tready === 1'b1) break;
            if (++t > TMO) begin
                n_checks++; n_fail++;
                $display("FAIL handshake_timeout: got no ready in %0d cycles, ready required", TMO);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 s_if.tvalid = 1'b0;
    endtask

    // header beats carry the length LSB first; trunc_at/abort_at < 0 disable those faults
    task automatic send_frame(input logic [FLW-1:0] len, input int nbeats,
                              input logic [KW-1:0] lastkeep, input int trunc_at,
                              input int abort_at);
        logic [W-1:0] d;
        logic [KW-1:0] k;
        longint bytes = 0;
        longint maxv = (64'd1 << FLW) - 1;
        for (int h = 0; h < HB; h++) begin
            d = len[h*W +: W];
            if (h == trunc_at) begin
                exp_trunc++;
                send_beat(d, '1, 1'b1, 1'b0);
                return;
            end
            if (h == HB - 1) exp_len.push_back(len);
            send_beat(d, '1, 1'b0, 1'b0);
        end
        @(negedge clk);
        #4;
        chk("length_latency_valid", l_if.tvalid, 1'b1);
        chk("length_latency_data", l_if.tdata, len);
        for (int i = 0; i < nbeats; i++) begin
            if (i == abort_at) return;
            d = W'($urandom);
            k = (i == nbeats - 1) ? lastkeep : '1;
            bytes += $countones(k);
            if (bytes > maxv) bytes = maxv;
            exp_beats.push_back('{d: d, k: k, l: (i == nbeats - 1)});
            send_beat(d, k, i == nbeats - 1, 1'b1);
        end
        if (CHECK_EN && bytes != longint'(len)) exp_lenerr++;
    endtask

    initial begin
        int nb;
        logic [FLW-1:0] ln;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        l_if.tready = 1'b1;
        repeat (3) @(negedge clk);
        #4;
        chk("reset_s_tready", s_if.tready, 1'b1);
        chk("reset_m_tvalid", m_if.tvalid, 1'b0);
        chk("reset_len_tvalid", l_if.tvalid, 1'b0);
        chk("reset_err_trunc", err_trunc, 1'b0);
        chk("reset_err_len", err_len, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // full-size frame, all sinks ready
        send_frame(FLW'(1518), 1518, '1, -1, -1);

        // length held off: frame A payload flows, frame B header blocked
        l_hold = 1'b1;
        fork
            begin
                send_frame(FLW'(100), 100, '1, -1, -1);
                a_done = 1'b1;
                send_frame(FLW'(60), 60, '1, -1, -1);
            end
            begin
                repeat (2000) @(negedge clk);
                l_hold = 1'b0;
            end
            begin
                wait (a_done);
                repeat (200) begin
                    @(negedge clk);
                    #4;
                    chk("hdr_blocked", s_if.tready, 1'b0);
                end
            end
        join

        // random backpressure and source gaps
        m_rdy_rand = 1'b1;
        gaps = 1'b1;
        for (int f = 0; f < 6; f++) begin
            nb = $urandom_range(1, 40);
            ln = ($urandom_range(0, 3) == 0) ? FLW'($urandom_range(0, 200)) : FLW'(nb * KW);
            send_frame(ln, nb, '1, -1, -1);
        end
        m_rdy_rand = 1'b0;
        gaps = 1'b0;

        // truncated headers, then a clean frame
        send_frame(FLW'(77), 5, '1, 0, -1);
        if (HB > 1) send_frame(FLW'(77), 5, '1, HB - 1, -1);
        send_frame(FLW'(20 * KW), 20, '1, -1, -1);

        // reset mid-payload, then a fresh 64-beat frame
        send_frame(FLW'(1518), 1518, '1, -1, 300);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #4;
        chk("post_rst_s_tready", s_if.tready, 1'b1);
        chk("post_rst_m_tvalid", m_if.tvalid, 1'b0);
        chk("post_rst_len_tvalid", l_if.tvalid, 1'b0);
        chk("post_rst_err_trunc", err_trunc, 1'b0);
        send_frame(FLW'(64), 64, '1, -1, -1);

`ifdef SPLIT_FRAME_LENGTH_CHECK_EN
        send_frame(FLW'(100), 25, 4'b0111, -1, -1);
        send_frame(FLW'(100), 25, 4'b1111, -1, -1);
`endif

        for (int t = 0; t < 100 && (exp_beats.size() != 0 || exp_len.size() != 0); t++)
            @(negedge clk);
        repeat (4) @(negedge clk);
        chk("frames_drained", exp_beats.size(), 0);
        chk("lengths_drained", exp_len.size(), 0);
        chk("err_truncated_count", obs_trunc, exp_trunc);
        chk("err_length_count", obs_lenerr, exp_lenerr);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, completion required");
        $fatal(1, "watchdog expired");
    end
endmodule
